// File: rtl/imm_decode_ctrl.sv
// rtl/imm_decode_ctrl.sv - decode-path sequencer for the shared immediate extender
//
// Accepts one instruction per in_valid/in_ready transfer. It decodes opcode/funct3
// into an immediate-type select and drives the external combinational extender
// for one cycle. It then captures the extended value and holds it for downstream
// under out_valid/out_ready. Opcodes outside the decode table are flagged, and a
// saturating counter records them.
//
// Ports
//   clk, reset               clock; asynchronous active-high reset
//   in_valid/in_ready        instruction handshake
//   in_instr, in_tag         instruction word and sideband tag
//   ext_in, ext_src          to extender: instr[31:7] and type select
//   ext_out                  from extender: 32-bit extended immediate
//   out_valid/out_ready      result handshake
//   out_imm, out_src         captured immediate and the select used
//   out_illegal, out_tag     illegal-opcode flag and carried tag
//   illegal_cnt              saturating count of accepted illegal instructions
module imm_decode_ctrl #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic [24:0]      ext_in,
    output logic [2:0]       ext_src,
    input  logic [31:0]      ext_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_imm,
    output logic [2:0]       out_src,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] SRC_I     = 3'b000;
    localparam logic [2:0] SRC_S     = 3'b001;
    localparam logic [2:0] SRC_B     = 3'b010;
    localparam logic [2:0] SRC_U     = 3'b011;
    localparam logic [2:0] SRC_J     = 3'b100;
    localparam logic [2:0] SRC_SHIFT = 3'b101;
    localparam logic [2:0] SRC_NONE  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXT  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        instr_q;
    logic [TAG_W-1:0]   tag_q;
    logic [2:0]         src_q;
    logic               illegal_q;
    logic [31:0]        imm_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [2:0]         dec_src;
    logic               dec_illegal;
    logic               load;
    logic               capture;
    logic               ready_raw;

    // Opcode/funct3 decode of the word currently offered on the input.
    always_comb begin
        dec_src     = SRC_NONE;
        dec_illegal = 1'b0;
        unique case (in_instr[6:0])
            7'b0010011: begin
                if (in_instr[14:12] == 3'b001 || in_instr[14:12] == 3'b101) begin
                    dec_src = SRC_SHIFT;
                end else begin
                    dec_src = SRC_I;
                end
            end
            7'b0000011,
            7'b1100111: dec_src = SRC_I;
            7'b0100011: dec_src = SRC_S;
            7'b1100011: dec_src = SRC_B;
            7'b0110111,
            7'b0010111: dec_src = SRC_U;
            7'b1101111: dec_src = SRC_J;
            7'b0110011: dec_src = SRC_NONE;
            default: begin
                dec_src     = SRC_NONE;
                dec_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        capture   = 1'b0;
        ready_raw = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_raw = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = EXT;
                end
            end
            EXT: begin
                capture = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                // A new word can be taken in the same cycle the result drains.
                ready_raw = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load    = 1'b1;
                        state_d = EXT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            tag_q     <= '0;
            src_q     <= '0;
            illegal_q <= 1'b0;
            imm_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                instr_q   <= in_instr;
                tag_q     <= in_tag;
                src_q     <= dec_src;
                illegal_q <= dec_illegal;
            end
            if (capture) begin
                // No-immediate and illegal words both carry SRC_NONE and report zero.
                imm_q <= (src_q == SRC_NONE) ? 32'h0 : ext_out;
                if (illegal_q && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // Reset gates ready directly so it reads 0 while reset is held.
    assign in_ready    = ready_raw & ~reset;
    assign ext_in      = instr_q[31:7];
    assign ext_src     = src_q;
    assign out_valid   = (state_q == HOLD);
    assign out_imm     = imm_q;
    assign out_src     = src_q;
    assign out_illegal = illegal_q;
    assign out_tag     = tag_q;
    assign illegal_cnt = cnt_q;

endmodule
